// File: rtl/request_frame_assembler.sv
// Assembles instruction/address (and optional XOR checksum) bytes from the UART
// receiver into a request presented to the main state machine via REQ_VALID/REQ_ACK.
module request_frame_assembler #(
  parameter int INSTR_W        = 3,
  parameter int ADDR_W         = 5,
  parameter int CHECK_EN       = 0,
  parameter int TIMEOUT_CYCLES = 2_500_000
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               RX_VALID,
  input  logic [7:0]         RX_DATA,
  input  logic               REQ_ACK,
  input  logic               CONTINUOUS_EN,
  output logic [INSTR_W-1:0] INSTR,
  output logic [ADDR_W-1:0]  ADDR,
  output logic               REQ_VALID,
  output logic               FRAME_ERR,
  output logic               OVERRUN
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {S_INSTR, S_ADDR, S_CHK} state_t;

  state_t             state_q, state_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic [7:0]         ib_q, ib_d, ab_q, ab_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               valid_q, valid_d;
  logic               ferr_q, ferr_d;
  logic               ovr_q, ovr_d;
  logic               timeout, commit, drop;

  always_comb begin
    state_d = state_q;
    timer_d = '0;
    ib_d    = ib_q;
    ab_d    = ab_q;
    commit  = 1'b0;
    drop    = 1'b0;
    timeout = (state_q != S_INSTR) && !RX_VALID &&
              (timer_q == TW'(TIMEOUT_CYCLES - 1));

    // A byte arriving on the timeout cycle takes priority and restarts the timer.
    case (state_q)
      S_INSTR: begin
        if (RX_VALID) begin
          ib_d    = RX_DATA;
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        if (RX_VALID) begin
          ab_d = RX_DATA;
          if (CHECK_EN != 0) begin
            state_d = S_CHK;
          end else begin
            commit  = 1'b1;
            state_d = S_INSTR;
          end
        end else if (timeout) begin
          drop    = 1'b1;
          state_d = S_INSTR;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_CHK: begin
        if (RX_VALID) begin
          state_d = S_INSTR;
          if (RX_DATA == (ib_q ^ ab_q)) commit = 1'b1;
          else                          drop   = 1'b1;
        end else if (timeout) begin
          drop    = 1'b1;
          state_d = S_INSTR;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = S_INSTR;
    endcase

    instr_d = instr_q;
    addr_d  = addr_q;
    valid_d = valid_q;
    ovr_d   = 1'b0;
    ferr_d  = drop;
    // A commit always wins over an ACK in the same cycle; only an un-ACKed overwrite is an overrun.
    if (commit) begin
      instr_d = ib_d[INSTR_W-1:0];
      addr_d  = ab_d[ADDR_W-1:0];
      valid_d = 1'b1;
      ovr_d   = valid_q && !REQ_ACK;
    end else if (REQ_ACK && valid_q && !CONTINUOUS_EN) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_INSTR;
      timer_q <= '0;
      ib_q    <= '0;
      ab_q    <= '0;
      instr_q <= '0;
      addr_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      ib_q    <= ib_d;
      ab_q    <= ab_d;
      instr_q <= instr_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign INSTR     = instr_q;
  assign ADDR      = addr_q;
  assign REQ_VALID = valid_q;
  assign FRAME_ERR = ferr_q;
  assign OVERRUN   = ovr_q;

endmodule

// File: tb/tb_request_frame_assembler.sv
// Bench for request_frame_assembler: two instances (checksum off / on) driven
// independently and compared every cycle against a frame-level reference model.
module tb_request_frame_assembler;

  localparam int T = 16;

  logic       CLK;
  logic       RST_N;
  logic       rxv  [2];
  logic [7:0] rxd  [2];
  logic       ack  [2];
  logic       cont [2];
  logic [2:0] instr_w [2];
  logic [4:0] addr_w  [2];
  logic       valid_w [2];
  logic       ferr_w  [2];
  logic       ovr_w   [2];

  request_frame_assembler #(.INSTR_W(3), .ADDR_W(5), .CHECK_EN(0), .TIMEOUT_CYCLES(T)) u0 (
    .CLK(CLK), .RST_N(RST_N), .RX_VALID(rxv[0]), .RX_DATA(rxd[0]), .REQ_ACK(ack[0]),
    .CONTINUOUS_EN(cont[0]), .INSTR(instr_w[0]), .ADDR(addr_w[0]), .REQ_VALID(valid_w[0]),
    .FRAME_ERR(ferr_w[0]), .OVERRUN(ovr_w[0]));

  request_frame_assembler #(.INSTR_W(3), .ADDR_W(5), .CHECK_EN(1), .TIMEOUT_CYCLES(T)) u1 (
    .CLK(CLK), .RST_N(RST_N), .RX_VALID(rxv[1]), .RX_DATA(rxd[1]), .REQ_ACK(ack[1]),
    .CONTINUOUS_EN(cont[1]), .INSTR(instr_w[1]), .ADDR(addr_w[1]), .REQ_VALID(valid_w[1]),
    .FRAME_ERR(ferr_w[1]), .OVERRUN(ovr_w[1]));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: partial frame kept as a list of bytes plus the edge index of the last byte.
  int unsigned m_instr [2];
  int unsigned m_addr  [2];
  bit          m_valid [2];
  bit          m_ferr  [2];
  bit          m_ovr   [2];
  logic [7:0]  m_fb    [2][3];
  int          m_cnt   [2];
  int          m_last  [2];
  int          edge_n = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_instr[m] = 0; m_addr[m] = 0; m_valid[m] = 0;
      m_ferr[m] = 0; m_ovr[m] = 0; m_cnt[m] = 0; m_last[m] = 0;
    end
  endtask

  task automatic model_step(input int m);
    bit commit;
    int need;
    need      = (m == 1) ? 3 : 2;
    commit    = 0;
    m_ferr[m] = 0;
    m_ovr[m]  = 0;
    if (m_cnt[m] > 0 && !rxv[m] && (edge_n - m_last[m]) == T) begin
      m_cnt[m]  = 0;
      m_ferr[m] = 1;
    end else if (rxv[m]) begin
      m_fb[m][m_cnt[m]] = rxd[m];
      m_cnt[m]++;
      m_last[m] = edge_n;
      if (m_cnt[m] == need) begin
        m_cnt[m] = 0;
        if (need == 2 || m_fb[m][2] == (m_fb[m][0] ^ m_fb[m][1])) commit = 1;
        else m_ferr[m] = 1;
      end
    end
    if (commit) begin
      m_ovr[m]   = m_valid[m] && !ack[m];
      m_instr[m] = m_fb[m][0] % 8;
      m_addr[m]  = m_fb[m][1] % 32;
      m_valid[m] = 1;
    end else if (ack[m] && m_valid[m] && !cont[m]) begin
      m_valid[m] = 0;
    end
  endtask

  task automatic compare_all();
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("u%0d.INSTR", m),     32'(instr_w[m]), m_instr[m]);
      chk($sformatf("u%0d.ADDR", m),      32'(addr_w[m]),  m_addr[m]);
      chk($sformatf("u%0d.REQ_VALID", m), 32'(valid_w[m]), 32'(m_valid[m]));
      chk($sformatf("u%0d.FRAME_ERR", m), 32'(ferr_w[m]),  32'(m_ferr[m]));
      chk($sformatf("u%0d.OVERRUN", m),   32'(ovr_w[m]),   32'(m_ovr[m]));
    end
  endtask

  task automatic cycle();
    @(posedge CLK);
    edge_n++;
    model_step(0);
    model_step(1);
    #1;
    compare_all();
  endtask

  task automatic tick(input int m, input bit v, input logic [7:0] d, input bit a, input bit c);
    for (int k = 0; k < 2; k++) begin
      rxv[k] = (k == m) ? v : 1'b0;
      rxd[k] = (k == m) ? d : 8'h00;
      ack[k] = (k == m) ? a : 1'b0;
      cont[k] = (k == m) ? c : 1'b0;
    end
    cycle();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 8'h00, 0, 0);
  endtask

  task automatic do_reset();
    for (int k = 0; k < 2; k++) begin
      rxv[k] = 0; rxd[k] = 0; ack[k] = 0; cont[k] = 0;
    end
    RST_N = 1'b0;
    #2;
    model_reset();
    compare_all();
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  initial begin
    RST_N = 1'b0;
    for (int k = 0; k < 2; k++) begin
      rxv[k] = 0; rxd[k] = 0; ack[k] = 0; cont[k] = 0;
    end
    #12;
    do_reset();

    // Basic two-byte frame and ACK
    tick(0, 1, 8'h03, 0, 0);
    tick(0, 1, 8'h11, 0, 0);
    chk("t1_instr", 32'(instr_w[0]), 3);
    chk("t1_addr",  32'(addr_w[0]), 17);
    chk("t1_valid", 32'(valid_w[0]), 1);
    tick(0, 0, 8'h00, 1, 0);
    chk("t1_ack", 32'(valid_w[0]), 0);

    // Checksum good then bad
    tick(1, 1, 8'h02, 0, 0);
    tick(1, 1, 8'h05, 0, 0);
    tick(1, 1, 8'h07, 0, 0);
    chk("t2_instr", 32'(instr_w[1]), 2);
    chk("t2_addr",  32'(addr_w[1]), 5);
    tick(1, 1, 8'h02, 0, 0);
    tick(1, 1, 8'h05, 0, 0);
    tick(1, 1, 8'h06, 0, 0);
    chk("t2_ferr",  32'(ferr_w[1]), 1);
    chk("t2_hold",  32'(instr_w[1]), 2);
    tick(1, 0, 8'h00, 1, 0);

    // Inter-byte timeout, then a fresh frame
    tick(0, 1, 8'h01, 0, 0);
    idle(T - 1);
    chk("t3_noerr_yet", 32'(ferr_w[0]), 0);
    idle(1);
    chk("t3_timeout", 32'(ferr_w[0]), 1);
    tick(0, 1, 8'h04, 0, 0);
    tick(0, 1, 8'h09, 0, 0);
    chk("t3_instr", 32'(instr_w[0]), 4);
    chk("t3_addr",  32'(addr_w[0]), 9);
    tick(0, 0, 8'h00, 1, 0);

    // Bytes landing exactly on the timeout cycle, twice in one frame
    tick(1, 1, 8'h01, 0, 0);
    for (int i = 0; i < T - 1; i++) tick(1, 0, 8'h00, 0, 0);
    tick(1, 1, 8'h02, 0, 0);
    chk("t4_no_ferr", 32'(ferr_w[1]), 0);
    for (int i = 0; i < T - 1; i++) tick(1, 0, 8'h00, 0, 0);
    tick(1, 1, 8'h03, 0, 0);
    chk("t4_instr", 32'(instr_w[1]), 1);
    chk("t4_addr",  32'(addr_w[1]), 2);
    tick(1, 0, 8'h00, 1, 0);

    // Continuous mode
    tick(0, 1, 8'h06, 0, 0);
    tick(0, 1, 8'h07, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, 8'h00, 1, 1);
      chk("t5_cont_valid", 32'(valid_w[0]), 1);
    end
    tick(0, 1, 8'h00, 0, 0);
    tick(0, 1, 8'h01, 0, 0);
    tick(0, 0, 8'h00, 1, 0);
    chk("t5_end", 32'(valid_w[0]), 0);

    // Overrun, then commit coinciding with ACK
    tick(0, 1, 8'h0a, 0, 0);
    tick(0, 1, 8'h0b, 0, 0);
    tick(0, 1, 8'h0c, 0, 0);
    tick(0, 1, 8'h0d, 0, 0);
    chk("t6_ovr",   32'(ovr_w[0]), 1);
    chk("t6_instr", 32'(instr_w[0]), 4);
    chk("t6_addr",  32'(addr_w[0]), 13);
    tick(0, 1, 8'h0e, 0, 0);
    tick(0, 1, 8'h2f, 1, 0);
    chk("t6_no_ovr", 32'(ovr_w[0]), 0);
    chk("t6_valid",  32'(valid_w[0]), 1);
    chk("t6_addr2",  32'(addr_w[0]), 15);

    // Reset mid-frame
    tick(0, 1, 8'h01, 0, 0);
    tick(1, 1, 8'h02, 0, 0);
    do_reset();
    tick(0, 1, 8'h02, 0, 0);
    tick(0, 1, 8'h03, 0, 0);
    chk("t6_clean_instr", 32'(instr_w[0]), 2);
    chk("t6_clean_addr",  32'(addr_w[0]), 3);

    // Randomized traffic on both instances
    begin
      int quiet [2];
      quiet[0] = 0; quiet[1] = 0;
      for (int n = 0; n < 4000; n++) begin
        if ($urandom_range(0, 699) == 0) do_reset();
        for (int m = 0; m < 2; m++) begin
          if (quiet[m] > 0) begin
            quiet[m]--;
            rxv[m] = 0;
          end else begin
            if ($urandom_range(0, 39) == 0) quiet[m] = $urandom_range(T - 2, T + 2);
            rxv[m] = ($urandom_range(0, 2) == 0);
          end
          rxd[m] = 8'($urandom);
          if (m == 1 && m_cnt[1] == 2 && $urandom_range(0, 2) != 0)
            rxd[m] = m_fb[1][0] ^ m_fb[1][1];
          ack[m]  = ($urandom_range(0, 4) == 0);
          cont[m] = ($urandom_range(0, 3) == 0);
        end
        cycle();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
